// File: rtl/row_plotter.sv
// Serialises pixel rows from a shift register into VGA plot writes.
// Option: ROW_PLOTTER_TRANSPARENT_BG_EN leaves background pixels unwritten.
module row_plotter #(
   parameter int          ROW_WIDTH = 128,
   parameter int          NUM_ROWS  = 120,
   parameter int          X_BITS    = 8,
   parameter int          Y_BITS    = 7,
   parameter int          X_ORIGIN  = 16,
   parameter logic [2:0]  FG_COLOUR = 3'b111,
   parameter logic [2:0]  BG_COLOUR = 3'b000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              row_valid,
   output logic              row_ready,
   output logic              sr_load,
   output logic              sr_shift,
   input  logic              sr_bit,
   output logic [X_BITS-1:0] vga_x,
   output logic [Y_BITS-1:0] vga_y,
   output logic [2:0]        vga_colour,
   output logic              vga_plot,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(ROW_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ROW,
      PLOT,
      DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [Y_BITS-1:0] row_q, row_d;
   logic            ready_q;
   logic            plot_q;
   logic            busy_q;
   logic            done_q;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_ROW;
               col_d   = '0;
               row_d   = '0;
            end
         end
         WAIT_ROW: begin
            if (row_valid) begin
               state_d = PLOT;
               col_d   = '0;
            end
         end
         PLOT: begin
            if (col_q == CW'(ROW_WIDTH - 1)) begin
               col_d = '0;
               if (row_q == Y_BITS'(NUM_ROWS - 1)) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = WAIT_ROW;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they align with it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         ready_q <= 1'b0;
         plot_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         ready_q <= (state_d == WAIT_ROW);
         plot_q  <= (state_d == PLOT);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
      end
   end

   assign row_ready = ready_q;
   assign sr_load   = ready_q & row_valid;
   assign sr_shift  = plot_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef ROW_PLOTTER_TRANSPARENT_BG_EN
   assign vga_plot = plot_q & sr_bit;
`else
   assign vga_plot = plot_q;
`endif

   assign vga_colour = vga_plot ? (sr_bit ? FG_COLOUR : BG_COLOUR) : 3'b000;
   assign vga_x      = plot_q ? X_BITS'(X_ORIGIN) + X_BITS'(col_q)
                              : '0;
   assign vga_y      = row_q;

endmodule

// File: tb/tb_row_plotter.sv
// Bench for row_plotter: random rows checked against a pixel-stream model.
module tb_row_plotter;

   localparam int RW = 128;
   localparam int NR = 120;
   localparam int XO = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         row_valid = 1'b0;
   logic         row_ready, sr_load, sr_shift, sr_bit;
   logic [7:0]   vga_x;
   logic [6:0]   vga_y;
   logic [2:0]   vga_colour;
   logic         vga_plot, busy, done;
   logic [127:0] row_value = '0;
   logic [127:0] sr_q;

   row_plotter dut (
      .clock(clock), .reset(reset), .start(start),
      .row_valid(row_valid), .row_ready(row_ready),
      .sr_load(sr_load), .sr_shift(sr_shift), .sr_bit(sr_bit),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Behavioural 128-bit pixel shift register feeding sr_bit.
   always_ff @(posedge clock) begin
      if (sr_load) sr_q <= row_value;
      else if (sr_shift) sr_q <= sr_q << 1;
   end
   assign sr_bit = sr_q[127];

   int errors = 0;
   int checks = 0;
   bit in_wait = 0, done_next = 0, frame_on = 0;
   int pix_left = 0, k = 0, cur_row = 0, rows_loaded = 0;
   logic [127:0] cur_val = '0;
   int plots = 0, shifts = 0, dones = 0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      bit b;
      if (!reset) begin
         in_wait = 0; done_next = 0; frame_on = 0;
         pix_left = 0; rows_loaded = 0;
         return;
      end
      if (vga_plot) plots++;
      if (sr_shift) shifts++;
      if (done) dones++;
      chk("ld_sh_excl", 128'(sr_load & sr_shift), 0);
      if (pix_left > 0) begin
         b = cur_val[RW-1-k];
         chk("shift", 128'(sr_shift), 1);
         chk("x", 128'(vga_x), XO + k);
         chk("y", 128'(vga_y), cur_row);
`ifdef ROW_PLOTTER_TRANSPARENT_BG_EN
         chk("plot", 128'(vga_plot), 128'(b));
         if (b) chk("colour", 128'(vga_colour), 7);
`else
         chk("plot", 128'(vga_plot), 1);
         chk("colour", 128'(vga_colour), b ? 7 : 0);
`endif
         chk("ready_plot", 128'(row_ready), 0);
         chk("load_plot", 128'(sr_load), 0);
         chk("busy_plot", 128'(busy), 1);
         chk("done_plot", 128'(done), 0);
         k++;
         pix_left--;
         if (pix_left == 0) begin
            if (cur_row == NR - 1) done_next = 1;
            else in_wait = 1;
         end
      end else if (done_next) begin
         chk("done", 128'(done), 1);
         chk("busy_done", 128'(busy), 1);
         chk("plot_done", 128'(vga_plot), 0);
         chk("ready_done", 128'(row_ready), 0);
         done_next = 0;
         frame_on = 0;
      end else if (in_wait) begin
         chk("ready_wait", 128'(row_ready), 1);
         chk("plot_wait", 128'(vga_plot), 0);
         chk("shift_wait", 128'(sr_shift), 0);
         chk("busy_wait", 128'(busy), 1);
         chk("done_wait", 128'(done), 0);
         chk("y_wait", 128'(vga_y), rows_loaded);
         chk("load", 128'(sr_load), 128'(row_valid));
         if (row_valid) begin
            in_wait = 0; pix_left = RW; k = 0;
            cur_row = rows_loaded; rows_loaded++;
            cur_val = row_value;
         end
      end else begin
         chk("busy_idle", 128'(busy), 0);
         chk("ready_idle", 128'(row_ready), 0);
         chk("load_idle", 128'(sr_load), 0);
         chk("shift_idle", 128'(sr_shift), 0);
         chk("plot_idle", 128'(vga_plot), 0);
         chk("done_idle", 128'(done), 0);
         chk("colour_idle", 128'(vga_colour), 0);
         chk("x_idle", 128'(vga_x), 0);
         if (rows_loaded == 0) chk("y_idle", 128'(vga_y), 0);
         if (start) begin
            in_wait = 1; frame_on = 1; rows_loaded = 0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      sample();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int cnt;
      int stall;
      int dones_before;
      bit hit;

      // Reset, then idle
      reset = 0;
      repeat (3) tick();
      reset = 1;
      repeat (3) tick();

      // Frame A: random stalls, a 10-cycle stall, reset at row 3 col 40
      start = 1;
      tick();
      start = 0;
      stall = 0;
      hit = 0;
      for (int c = 0; c < 20000; c++) begin
         if (pix_left > 0 && cur_row == 3 && k == 40) begin
            hit = 1;
            break;
         end
         row_value = rnd128();
         start = ($urandom_range(15) == 0);
         if (in_wait && rows_loaded == 1 && stall < 10) begin
            row_valid = 0;
            stall++;
         end else begin
            row_valid = ($urandom_range(3) != 0);
         end
         tick();
      end
      chk("reach_reset_pt", 128'(hit), 1);
      start = 0;
      dones_before = dones;
      reset = 0;
      repeat (2) tick();
      reset = 1;
      row_valid = $urandom_range(1);
      repeat (4) tick();
      chk("no_done_reset", dones, dones_before);

      // Frame B: row_valid tied high, start pulsed mid-frame
      plots = 0; shifts = 0; dones = 0;
      row_valid = 1;
      start = 1;
      row_value = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
      tick();
      cnt = 1;
      start = 0;
      while (frame_on && cnt < 20000) begin
         start = (rows_loaded == 6 && pix_left == 10);
         if (rows_loaded == 0)
            row_value = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
         else if (rows_loaded == 1)
            row_value = {64{2'b10}};
         else
            row_value = rnd128();
         tick();
         cnt++;
      end
      start = 0;
      chk("frame_len", cnt, NR * (RW + 1) + 2);
      chk("shift_count", shifts, NR * RW);
`ifndef ROW_PLOTTER_TRANSPARENT_BG_EN
      chk("plot_count", plots, NR * RW);
`endif
      chk("done_count", dones, 1);
      chk("busy_drop", 128'(busy), 0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
